sntc_ldpc_decode_ctrl: RTL and testbench

//  Sequencer for one sntc_ldpc_decoder_wrapper instance. Accepts a decode request, pulses the decoder

---
 rtl/sntc_ldpc_ctrl_pkg.sv | 8 +
 rtl/sntc_sat_cntr.sv | 33 +++
 rtl/sntc_ldpc_decode_ctrl.sv | 174 +++++++++++++++++
 tb/tb_sntc_ldpc_decode_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sntc_ldpc_ctrl_pkg.sv
// Shared types for the LDPC decode sequencer.
package sntc_ldpc_ctrl_pkg;

    typedef enum logic [1:0] {IDLE, LAUNCH, RUN, DONE} ctrl_state_t;

    typedef enum logic [1:0] {ST_OK, ST_MAXITER, ST_STUCK, ST_TIMEOUT} dec_status_t;

endpackage

// File: rtl/sntc_sat_cntr.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sntc_sat_cntr #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/sntc_ldpc_decode_ctrl.sv
// Sequencer for one LDPC decoder: launch, count iterations, terminate, report result and
// keep saturating ok/fail statistics.
module sntc_ldpc_decode_ctrl
    import sntc_ldpc_ctrl_pkg::*;
#(
    parameter int unsigned SUM_LEN = 32,
    parameter int unsigned ITER_W  = 16,
    parameter int unsigned WDOG_W  = 20,
    parameter int unsigned STAT_W  = 16
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               clr,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [ITER_W-1:0]  max_iter,
    input  logic [WDOG_W-1:0]  wdog_cycles,
    output logic               dec_start,
    input  logic [1:0]         dec_converged,
    input  logic               dec_conv_valid,
    input  logic               dec_valid_cword,
    input  logic [SUM_LEN-1:0] dec_hamdist,
    output logic               done_valid,
    input  logic               done_ready,
    output logic [1:0]         done_status,
    output logic [ITER_W-1:0]  done_iter,
    output logic [SUM_LEN-1:0] done_hamdist,
    output logic               busy,
    output logic [STAT_W-1:0]  stat_ok,
    output logic [STAT_W-1:0]  stat_fail
);

    localparam int unsigned IterXW = ITER_W + 1;

    ctrl_state_t        state_q, state_d;
    logic [ITER_W-1:0]  max_q, max_d;
    logic [WDOG_W-1:0]  wlim_q, wlim_d;
    logic [WDOG_W-1:0]  wd_q, wd_d;
    dec_status_t        status_q, status_d;
    logic [ITER_W-1:0]  diter_q, diter_d;
    logic [SUM_LEN-1:0] dham_q, dham_d;

    logic [ITER_W-1:0] iter;
    logic [ITER_W-1:0] iter_next;
    logic [IterXW-1:0] iter_p1;
    logic              accept, in_run, conv, hs;
    logic              term;
    dec_status_t       term_status;

    assign accept  = (state_q == IDLE) && req_valid;
    assign in_run  = (state_q == RUN);
    assign conv    = in_run && dec_conv_valid;
    assign hs      = (state_q == DONE) && done_ready;
    assign iter_p1 = {1'b0, iter} + IterXW'(1);
    assign iter_next = (iter == '1) ? iter : iter_p1[ITER_W-1:0];

    // Termination priority: codeword, stuck, iteration limit, watchdog.
    always_comb begin
        term        = 1'b0;
        term_status = ST_OK;
        if (in_run) begin
            if (dec_valid_cword) begin
                term        = 1'b1;
                term_status = ST_OK;
            end else if (dec_conv_valid && dec_converged[1]) begin
                term        = 1'b1;
                term_status = ST_STUCK;
            end else if (dec_conv_valid && (iter_p1 >= {1'b0, max_q})) begin
                term        = 1'b1;
                term_status = ST_MAXITER;
            end else if ((wlim_q != '0) && (wd_q == wlim_q - WDOG_W'(1))) begin
                term        = 1'b1;
                term_status = ST_TIMEOUT;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        max_d    = max_q;
        wlim_d   = wlim_q;
        wd_d     = wd_q;
        status_d = status_q;
        diter_d  = diter_q;
        dham_d   = dham_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d = LAUNCH;
                    max_d   = (max_iter == '0) ? ITER_W'(1) : max_iter;
                    wlim_d  = wdog_cycles;
                    wd_d    = '0;
                end
            end
            LAUNCH: state_d = RUN;
            RUN: begin
                wd_d = dec_conv_valid ? '0 : wd_q + WDOG_W'(1);
                if (term) begin
                    state_d  = DONE;
                    status_d = term_status;
                    diter_d  = dec_conv_valid ? iter_next : iter;
                    dham_d   = dec_hamdist;
                end
            end
            DONE: begin
                if (done_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Synchronous clear behaves exactly like reset.
        if (clr) begin
            state_d  = IDLE;
            max_d    = '0;
            wlim_d   = '0;
            wd_d     = '0;
            status_d = ST_OK;
            diter_d  = '0;
            dham_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            max_q    <= '0;
            wlim_q   <= '0;
            wd_q     <= '0;
            status_q <= ST_OK;
            diter_q  <= '0;
            dham_q   <= '0;
        end else begin
            state_q  <= state_d;
            max_q    <= max_d;
            wlim_q   <= wlim_d;
            wd_q     <= wd_d;
            status_q <= status_d;
            diter_q  <= diter_d;
            dham_q   <= dham_d;
        end
    end

    sntc_sat_cntr #(.W(ITER_W)) u_iter (
        .clk  (clk),
        .rstn (rstn),
        .clr  (clr | accept),
        .inc  (conv),
        .cnt  (iter)
    );

    sntc_sat_cntr #(.W(STAT_W)) u_stat_ok (
        .clk  (clk),
        .rstn (rstn),
        .clr  (clr),
        .inc  (hs && (status_q == ST_OK)),
        .cnt  (stat_ok)
    );

    sntc_sat_cntr #(.W(STAT_W)) u_stat_fail (
        .clk  (clk),
        .rstn (rstn),
        .clr  (clr),
        .inc  (hs && (status_q != ST_OK)),
        .cnt  (stat_fail)
    );

    assign req_ready    = (state_q == IDLE);
    assign dec_start    = (state_q == LAUNCH);
    assign busy         = (state_q != IDLE);
    assign done_valid   = (state_q == DONE);
    assign done_status  = status_q;
    assign done_iter    = diter_q;
    assign done_hamdist = dham_q;

endmodule

// File: tb/tb_sntc_ldpc_decode_ctrl.sv
// Directed bench for sntc_ldpc_decode_ctrl; a second instance with narrow stats shows saturation.
module tb_sntc_ldpc_decode_ctrl;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        clr = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [15:0] max_iter = '0;
    logic [19:0] wdog_cycles = '0;
    logic        dec_start;
    logic [1:0]  dec_converged = '0;
    logic        dec_conv_valid = 1'b0;
    logic        dec_valid_cword = 1'b0;
    logic [31:0] dec_hamdist = '0;
    logic        done_valid;
    logic        done_ready = 1'b0;
    logic [1:0]  done_status;
    logic [15:0] done_iter;
    logic [31:0] done_hamdist;
    logic        busy;
    logic [15:0] stat_ok;
    logic [15:0] stat_fail;

    logic        d2_req_ready, d2_dec_start, d2_done_valid, d2_busy;
    logic [1:0]  d2_done_status;
    logic [15:0] d2_done_iter;
    logic [31:0] d2_done_hamdist;
    logic [1:0]  d2_stat_ok, d2_stat_fail;

    int checks = 0;
    int failures = 0;
    int starts = 0;
    int start_base;
    int n;

    always #5 clk = ~clk;

    always @(posedge clk) if (dec_start) starts++;

    sntc_ldpc_decode_ctrl dut (
        .clk (clk), .rstn (rstn), .clr (clr),
        .req_valid (req_valid), .req_ready (req_ready),
        .max_iter (max_iter), .wdog_cycles (wdog_cycles),
        .dec_start (dec_start), .dec_converged (dec_converged),
        .dec_conv_valid (dec_conv_valid), .dec_valid_cword (dec_valid_cword),
        .dec_hamdist (dec_hamdist),
        .done_valid (done_valid), .done_ready (done_ready),
        .done_status (done_status), .done_iter (done_iter), .done_hamdist (done_hamdist),
        .busy (busy), .stat_ok (stat_ok), .stat_fail (stat_fail)
    );

    sntc_ldpc_decode_ctrl #(.STAT_W(2)) dut2 (
        .clk (clk), .rstn (rstn), .clr (clr),
        .req_valid (req_valid), .req_ready (d2_req_ready),
        .max_iter (max_iter), .wdog_cycles (wdog_cycles),
        .dec_start (d2_dec_start), .dec_converged (dec_converged),
        .dec_conv_valid (dec_conv_valid), .dec_valid_cword (dec_valid_cword),
        .dec_hamdist (dec_hamdist),
        .done_valid (d2_done_valid), .done_ready (done_ready),
        .done_status (d2_done_status), .done_iter (d2_done_iter), .done_hamdist (d2_done_hamdist),
        .busy (d2_busy), .stat_ok (d2_stat_ok), .stat_fail (d2_stat_fail)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_accept(input logic [15:0] mi, input logic [19:0] wd);
        max_iter    = mi;
        wdog_cycles = wd;
        req_valid   = 1'b1;
        tick();
        req_valid   = 1'b0;
    endtask

    task automatic pulse_conv(input logic [1:0] cv, input logic cw, input logic [31:0] hd);
        dec_conv_valid  = 1'b1;
        dec_converged   = cv;
        dec_valid_cword = cw;
        dec_hamdist     = hd;
        tick();
        dec_conv_valid  = 1'b0;
        dec_converged   = 2'b00;
        dec_valid_cword = 1'b0;
    endtask

    task automatic handshake();
        done_ready = 1'b1;
        tick();
        done_ready = 1'b0;
    endtask

    task automatic fail_run();
        do_accept(16'd1, 20'd0);
        tick();
        pulse_conv(2'b00, 1'b0, 32'd9);
        chk("fr_status", 64'(done_status), 64'd1);
        handshake();
    endtask

    initial begin
        // Reset state
        repeat (2) tick();
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done_valid", 64'(done_valid), 64'd0);
        chk("rst_dec_start", 64'(dec_start), 64'd0);
        rstn = 1'b1;
        tick();
        chk("idle_req_ready", 64'(req_ready), 64'd1);
        chk("rst_stats", 64'({stat_ok, stat_fail}), 64'd0);

        // 1: valid codeword on third iteration
        start_base = starts;
        do_accept(16'd10, 20'd0);
        chk("t1_dec_start", 64'(dec_start), 64'd1);
        chk("t1_busy", 64'(busy), 64'd1);
        chk("t1_req_ready", 64'(req_ready), 64'd0);
        tick();
        chk("t1_start_one_cycle", 64'(dec_start), 64'd0);
        pulse_conv(2'b00, 1'b0, 32'd20);
        tick();
        pulse_conv(2'b00, 1'b0, 32'd11);
        tick();
        chk("t1_not_done_yet", 64'(done_valid), 64'd0);
        pulse_conv(2'b01, 1'b1, 32'd0);
        chk("t1_done_valid", 64'(done_valid), 64'd1);
        chk("t1_status", 64'(done_status), 64'd0);
        chk("t1_iter", 64'(done_iter), 64'd3);
        chk("t1_hamdist", 64'(done_hamdist), 64'd0);
        handshake();
        chk("t1_stat_ok", 64'(stat_ok), 64'd1);
        chk("t1_stat_fail", 64'(stat_fail), 64'd0);
        chk("t1_start_pulses", 64'(starts - start_base), 64'd1);
        chk("t1_back_idle", 64'(req_ready), 64'd1);

        // 2: iteration limit; a conv pulse in IDLE must be ignored
        pulse_conv(2'b00, 1'b0, 32'd1);
        do_accept(16'd4, 20'd0);
        tick();
        for (int i = 0; i < 3; i++) begin
            pulse_conv(2'b00, 1'b0, 32'd5);
            tick();
        end
        chk("t2_not_done_yet", 64'(done_valid), 64'd0);
        pulse_conv(2'b00, 1'b0, 32'd7);
        chk("t2_done_valid", 64'(done_valid), 64'd1);
        chk("t2_status", 64'(done_status), 64'd1);
        chk("t2_iter", 64'(done_iter), 64'd4);
        chk("t2_hamdist", 64'(done_hamdist), 64'd7);
        handshake();
        chk("t2_stat_fail", 64'(stat_fail), 64'd1);
        chk("t2_stat_ok", 64'(stat_ok), 64'd1);

        // 3: stuck at iteration 2
        do_accept(16'd10, 20'd0);
        tick();
        pulse_conv(2'b00, 1'b0, 32'd3);
        pulse_conv(2'b10, 1'b0, 32'd4);
        chk("t3_done_valid", 64'(done_valid), 64'd1);
        chk("t3_status", 64'(done_status), 64'd2);
        chk("t3_iter", 64'(done_iter), 64'd2);
        handshake();
        chk("t3_stat_fail", 64'(stat_fail), 64'd2);

        // 4: watchdog of 50 with no iterations
        dec_hamdist = 32'h55;
        do_accept(16'd10, 20'd50);
        chk("t4_dec_start", 64'(dec_start), 64'd1);
        n = 0;
        while (!done_valid && n < 200) begin
            tick();
            n++;
        end
        chk("t4_latency", 64'(n), 64'd51);
        chk("t4_status", 64'(done_status), 64'd3);
        chk("t4_iter", 64'(done_iter), 64'd0);
        chk("t4_hamdist", 64'(done_hamdist), 64'h55);
        handshake();
        chk("t4_stat_fail", 64'(stat_fail), 64'd3);
        chk("t4_d2_stat_fail", 64'(d2_stat_fail), 64'd3);

        // 5: result held under back-pressure, then clear mid-RUN
        do_accept(16'd2, 20'd0);
        tick();
        pulse_conv(2'b00, 1'b0, 32'd8);
        pulse_conv(2'b00, 1'b0, 32'd6);
        for (int i = 0; i < 20; i++) begin
            req_valid = 1'b1;
            tick();
            chk("t5_hold_valid", 64'(done_valid), 64'd1);
            chk("t5_hold_fields", 64'({done_status, done_iter, done_hamdist}),
                64'({2'd1, 16'd2, 32'd6}));
            chk("t5_hold_req_ready", 64'(req_ready), 64'd0);
        end
        req_valid = 1'b0;
        chk("t5_no_extra_start", 64'(dec_start), 64'd0);
        handshake();
        chk("t5_stat_fail", 64'(stat_fail), 64'd4);
        chk("t5_d2_stat_fail_sat", 64'(d2_stat_fail), 64'd3);
        do_accept(16'd5, 20'd0);
        tick();
        tick();
        chk("t5_busy_run", 64'(busy), 64'd1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("t5_clr_idle", 64'(req_ready), 64'd1);
        chk("t5_clr_busy", 64'(busy), 64'd0);
        chk("t5_clr_done_valid", 64'(done_valid), 64'd0);
        // clr clears the statistics just like reset; the aborted decode adds nothing
        chk("t5_clr_stats", 64'({stat_ok, stat_fail}), 64'd0);
        tick();
        chk("t5_no_restart", 64'(dec_start), 64'd0);

        // 6: max_iter=0 acts as 1; codeword and iteration on the same cycle
        do_accept(16'd0, 20'd0);
        tick();
        pulse_conv(2'b00, 1'b1, 32'd0);
        chk("t6_status", 64'(done_status), 64'd0);
        chk("t6_iter", 64'(done_iter), 64'd1);
        handshake();
        chk("t6_stat_ok", 64'(stat_ok), 64'd1);
        for (int i = 0; i < 3; i++) fail_run();
        chk("t6_stat_fail_3", 64'(stat_fail), 64'd3);
        chk("t6_d2_fail_at_max", 64'(d2_stat_fail), 64'd3);
        fail_run();
        chk("t6_stat_fail_4", 64'(stat_fail), 64'd4);
        chk("t6_d2_fail_held", 64'(d2_stat_fail), 64'd3);
        chk("t6_d2_stat_ok", 64'(d2_stat_ok), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
